// File: rtl/eth_tx_link_steering_if.sv
// TX frame stream bundle: start/valid/commit/drop strobes plus per-word and per-frame fields.
// The master drives every signal; the slave only observes.
interface eth_tx_link_steering_if #(
    parameter int DATA_WIDTH = 32
) ();
    localparam int BV_W = $clog2(DATA_WIDTH / 8) + 1;

    logic                  start;
    logic                  data_valid;
    logic [BV_W-1:0]       bytes_valid;
    logic [DATA_WIDTH-1:0] data;
    logic [47:0]           dst_mac;
    logic [15:0]           ethertype;
    logic                  commit;
    logic                  drop;

    modport master (
        output start, data_valid, bytes_valid, data, dst_mac, ethertype, commit, drop
    );
    modport slave (
        input  start, data_valid, bytes_valid, data, dst_mac, ethertype, commit, drop
    );
endinterface

// File: rtl/eth_tx_link_steering.sv
// Steers whole TX frames to the 10G port (preferred) or the 1G port, aborting cleanly on link loss.
// Latency: 1 cycle, all outputs registered. No backpressure: downstream buffers absorb or drop.
module eth_tx_link_steering #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_baser_link_up,
    input  logic                  i_baset_link_up,
    eth_tx_link_steering_if.slave  i_up,
    eth_tx_link_steering_if.master o_baser,
    eth_tx_link_steering_if.master o_baset,
    output logic [1:0]            o_active_port,
    output logic [CNT_WIDTH-1:0]  o_frames_baser,
    output logic [CNT_WIDTH-1:0]  o_frames_baset,
    output logic [CNT_WIDTH-1:0]  o_frames_dropped
);
    // Encoding doubles as the active_port value.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FWD_R   = 2'd1,
        FWD_T   = 2'd2,
        DISCARD = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_nxt;
    // Strobe vectors ordered {start, data_valid, commit, drop}.
    logic [3:0] w_r;
    logic [3:0] w_t;
    logic [3:0] w_cur;
    logic       w_link;
    logic       w_end;
    logic       w_take;
    logic [1:0] w_drop_amt;

    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] c,
                                                     input logic [1:0] a);
        logic [CNT_WIDTH:0] s;
        s = {1'b0, c} + {{(CNT_WIDTH-1){1'b0}}, a};
        return s[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : s[CNT_WIDTH-1:0];
    endfunction

    always_comb begin
        w_nxt      = r_state;
        w_r        = 4'b0000;
        w_t        = 4'b0000;
        w_cur      = 4'b0000;
        w_take     = 1'b0;
        w_drop_amt = 2'd0;
        w_link     = (r_state == FWD_R) ? i_baser_link_up : i_baset_link_up;
        w_end      = i_up.commit | i_up.drop;

        case (r_state)
            IDLE: w_take = i_up.start;
            FWD_R, FWD_T: begin
                w_take = i_up.start;
                if (!w_link) begin
                    w_cur[0]   = 1'b1;
                    w_drop_amt = 2'd1;
                    w_nxt      = w_end ? IDLE : DISCARD;
                end else if (w_end) begin
                    w_cur[2] = i_up.data_valid;
                    w_cur[1] = i_up.commit;
                    w_cur[0] = ~i_up.commit;
                    w_nxt    = IDLE;
                end else if (i_up.start) begin
                    // Start while a frame is open: abort the old one, then re-decide below.
                    w_cur[0]   = 1'b1;
                    w_drop_amt = 2'd1;
                end else begin
                    w_cur[2] = i_up.data_valid;
                end
                if (r_state == FWD_R) w_r = w_cur;
                else                  w_t = w_cur;
            end
            DISCARD: begin
                w_take = i_up.start;
                if (w_end) w_nxt = IDLE;
            end
            default: w_nxt = IDLE;
        endcase

        if (w_take) begin
            if (i_baser_link_up) begin
                w_r[3] = 1'b1;
                w_r[2] = i_up.data_valid;
                w_nxt  = FWD_R;
            end else if (i_baset_link_up) begin
                w_t[3] = 1'b1;
                w_t[2] = i_up.data_valid;
                w_nxt  = FWD_T;
            end else begin
                w_nxt      = DISCARD;
                w_drop_amt = w_drop_amt + 2'd1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state             <= IDLE;
            o_baser.start       <= 1'b0;
            o_baser.data_valid  <= 1'b0;
            o_baser.commit      <= 1'b0;
            o_baser.drop        <= 1'b0;
            o_baser.bytes_valid <= '0;
            o_baser.data        <= '0;
            o_baser.dst_mac     <= '0;
            o_baser.ethertype   <= '0;
            o_baset.start       <= 1'b0;
            o_baset.data_valid  <= 1'b0;
            o_baset.commit      <= 1'b0;
            o_baset.drop        <= 1'b0;
            o_baset.bytes_valid <= '0;
            o_baset.data        <= '0;
            o_baset.dst_mac     <= '0;
            o_baset.ethertype   <= '0;
            o_frames_baser      <= '0;
            o_frames_baset      <= '0;
            o_frames_dropped    <= '0;
        end else begin
            r_state             <= w_nxt;
            o_baser.start       <= w_r[3];
            o_baser.data_valid  <= w_r[2];
            o_baser.commit      <= w_r[1];
            o_baser.drop        <= w_r[0];
            o_baser.bytes_valid <= i_up.bytes_valid;
            o_baser.data        <= i_up.data;
            o_baser.dst_mac     <= i_up.dst_mac;
            o_baser.ethertype   <= i_up.ethertype;
            o_baset.start       <= w_t[3];
            o_baset.data_valid  <= w_t[2];
            o_baset.commit      <= w_t[1];
            o_baset.drop        <= w_t[0];
            o_baset.bytes_valid <= i_up.bytes_valid;
            o_baset.data        <= i_up.data;
            o_baset.dst_mac     <= i_up.dst_mac;
            o_baset.ethertype   <= i_up.ethertype;
            o_frames_baser      <= sat_add(o_frames_baser, {1'b0, w_r[1]});
            o_frames_baset      <= sat_add(o_frames_baset, {1'b0, w_t[1]});
            o_frames_dropped    <= sat_add(o_frames_dropped, w_drop_amt);
        end
    end

    assign o_active_port = r_state;
endmodule

// File: tb/tb_eth_tx_link_steering.sv
// Directed bench for eth_tx_link_steering: per-cycle expected strobes queued at drive time, popped after the edge.
// Counters are narrowed so saturation is reachable in a short run.
module tb_eth_tx_link_steering;
    localparam int DW = 32;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst;
    logic baser_up;
    logic baset_up;
    logic [1:0]    active_port;
    logic [CW-1:0] frames_baser;
    logic [CW-1:0] frames_baset;
    logic [CW-1:0] frames_dropped;

    always #5 clk = ~clk;

    eth_tx_link_steering_if #(.DATA_WIDTH(DW)) up_if ();
    eth_tx_link_steering_if #(.DATA_WIDTH(DW)) r_if ();
    eth_tx_link_steering_if #(.DATA_WIDTH(DW)) t_if ();

    eth_tx_link_steering #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_baser_link_up  (baser_up),
        .i_baset_link_up  (baset_up),
        .i_up             (up_if),
        .o_baser          (r_if),
        .o_baset          (t_if),
        .o_active_port    (active_port),
        .o_frames_baser   (frames_baser),
        .o_frames_baset   (frames_baset),
        .o_frames_dropped (frames_dropped)
    );

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] t;
        logic [1:0] ap;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One upstream cycle; expected strobes are {start, data_valid, commit, drop} per port.
    task automatic step(input logic st, input logic dv, input logic cm, input logic dp,
                        input logic [3:0] er, input logic [3:0] et, input logic [1:0] ap,
                        input string tag);
        logic [DW-1:0] d;
        logic [63:0]   rnd;
        exp_t          e;
        d   = $urandom;
        rnd = {$urandom, $urandom};
        up_if.start       = st;
        up_if.data_valid  = dv;
        up_if.commit      = cm;
        up_if.drop        = dp;
        up_if.data        = d;
        up_if.dst_mac     = rnd[47:0];
        up_if.bytes_valid = 3'd4;
        up_if.ethertype   = 16'h0800;
        sb_q.push_back('{r: er, t: et, ap: ap});
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk(tag, 128'({r_if.start, r_if.data_valid, r_if.commit, r_if.drop,
                       t_if.start, t_if.data_valid, t_if.commit, t_if.drop, active_port}),
            128'({e.r, e.t, e.ap}));
        chk({tag, "_fields"}, 128'({r_if.data, t_if.data, t_if.dst_mac}),
            128'({d, d, rnd[47:0]}));
    endtask

    initial begin
        rst      = 1'b1;
        baser_up = 1'b1;
        baset_up = 1'b1;
        up_if.start = 1'b0; up_if.data_valid = 1'b0; up_if.commit = 1'b0; up_if.drop = 1'b0;
        up_if.data = '0; up_if.dst_mac = '0; up_if.bytes_valid = '0; up_if.ethertype = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_strobes", 128'({r_if.start, r_if.data_valid, r_if.commit, r_if.drop,
                                   t_if.start, t_if.data_valid, t_if.commit, t_if.drop, active_port}), 128'(0));
        chk("reset_counters", 128'({frames_baser, frames_baset, frames_dropped}), 128'(0));
        chk("reset_fields", 128'({r_if.data, t_if.dst_mac, r_if.ethertype}), 128'(0));
        rst = 1'b0;

        // 64-byte frame with both links up goes to 10G.
        step(1, 1, 0, 0, 4'b1100, 4'b0000, 2'd1, "t1_start");
        for (int i = 0; i < 15; i++) step(0, 1, 0, 0, 4'b0100, 4'b0000, 2'd1, "t1_word");
        step(0, 0, 1, 0, 4'b0010, 4'b0000, 2'd0, "t1_commit");
        chk("t1_counts", 128'({frames_baser, frames_baset}), 128'({4'd1, 4'd0}));
        step(0, 0, 0, 0, 4'b0000, 4'b0000, 2'd0, "idle");

        // 10G down: two back-to-back frames on 1G.
        baser_up = 1'b0;
        for (int f = 0; f < 2; f++) begin
            step(1, 1, 0, 0, 4'b0000, 4'b1100, 2'd2, "t2_start");
            for (int i = 0; i < 2; i++) step(0, 1, 0, 0, 4'b0000, 4'b0100, 2'd2, "t2_word");
            step(0, 0, 1, 0, 4'b0000, 4'b0010, 2'd0, "t2_commit");
        end
        chk("t2_baset", 128'(frames_baset), 128'(4'd2));

        // 10G rises mid-frame: frame stays on 1G; next frame moves to 10G.
        step(1, 1, 0, 0, 4'b0000, 4'b1100, 2'd2, "t3_start");
        for (int w = 2; w <= 6; w++) begin
            if (w == 5) baser_up = 1'b1;
            step(0, 1, 0, 0, 4'b0000, 4'b0100, 2'd2, "t3_word");
        end
        step(0, 0, 1, 0, 4'b0000, 4'b0010, 2'd0, "t3_commit");
        chk("t3_baset", 128'(frames_baset), 128'(4'd3));
        step(1, 1, 0, 0, 4'b1100, 4'b0000, 2'd1, "t3_next_start");
        step(0, 0, 1, 0, 4'b0010, 4'b0000, 2'd0, "t3_next_commit");
        chk("t3_baser", 128'(frames_baser), 128'(4'd2));

        // 10G drops at word 8: one drop pulse, rest suppressed.
        step(1, 1, 0, 0, 4'b1100, 4'b0000, 2'd1, "t4_start");
        for (int w = 2; w <= 7; w++) step(0, 1, 0, 0, 4'b0100, 4'b0000, 2'd1, "t4_word");
        baser_up = 1'b0;
        step(0, 1, 0, 0, 4'b0001, 4'b0000, 2'd3, "t4_linkdown");
        for (int w = 9; w <= 16; w++) step(0, 1, 0, 0, 4'b0000, 4'b0000, 2'd3, "t4_discard");
        step(0, 0, 1, 0, 4'b0000, 4'b0000, 2'd0, "t4_commit");
        chk("t4_counts", 128'({frames_dropped, frames_baser}), 128'({4'd1, 4'd2}));

        // Both down: whole frame discarded, next frame goes to 1G once it is up.
        baset_up = 1'b0;
        step(1, 0, 0, 0, 4'b0000, 4'b0000, 2'd3, "t5_start");
        for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 4'b0000, 4'b0000, 2'd3, "t5_word");
        step(0, 0, 1, 0, 4'b0000, 4'b0000, 2'd0, "t5_commit");
        chk("t5_dropped", 128'(frames_dropped), 128'(4'd2));
        baset_up = 1'b1;
        step(1, 1, 0, 0, 4'b0000, 4'b1100, 2'd2, "t5_next_start");
        step(0, 0, 1, 0, 4'b0000, 4'b0010, 2'd0, "t5_next_commit");
        chk("t5_baset", 128'(frames_baset), 128'(4'd4));

        // Link falls in the commit cycle: drop instead of commit.
        baser_up = 1'b1;
        step(1, 1, 0, 0, 4'b1100, 4'b0000, 2'd1, "t6_start");
        step(0, 1, 0, 0, 4'b0100, 4'b0000, 2'd1, "t6_word");
        baser_up = 1'b0;
        step(0, 0, 1, 0, 4'b0001, 4'b0000, 2'd0, "t6_commit_linkdown");
        step(0, 0, 0, 0, 4'b0000, 4'b0000, 2'd0, "t6_idle");
        chk("t6_counts", 128'({frames_dropped, frames_baser}), 128'({4'd3, 4'd2}));

        // Stray strobes in IDLE are ignored.
        baser_up = 1'b1;
        step(0, 1, 1, 0, 4'b0000, 4'b0000, 2'd0, "idle_stray_commit");
        step(0, 1, 0, 1, 4'b0000, 4'b0000, 2'd0, "idle_stray_drop");

        // Start without commit: drop old frame and start the new one in the same cycle.
        step(1, 1, 0, 0, 4'b1100, 4'b0000, 2'd1, "t7_start");
        step(0, 1, 0, 0, 4'b0100, 4'b0000, 2'd1, "t7_word");
        step(1, 1, 0, 0, 4'b1101, 4'b0000, 2'd1, "t7_restart");
        step(0, 0, 1, 0, 4'b0010, 4'b0000, 2'd0, "t7_commit");
        chk("t7_counts", 128'({frames_dropped, frames_baser}), 128'({4'd4, 4'd3}));

        // Drop counter saturates at all-ones.
        baser_up = 1'b0;
        baset_up = 1'b0;
        for (int i = 0; i < 11; i++) begin
            step(1, 0, 0, 0, 4'b0000, 4'b0000, 2'd3, "t8_start");
            step(0, 0, 1, 0, 4'b0000, 4'b0000, 2'd0, "t8_commit");
        end
        chk("t8_reach_max", 128'(frames_dropped), 128'(4'hF));
        for (int i = 0; i < 2; i++) begin
            step(1, 0, 0, 0, 4'b0000, 4'b0000, 2'd3, "t8_start");
            step(0, 0, 1, 0, 4'b0000, 4'b0000, 2'd0, "t8_commit");
        end
        chk("t8_saturated", 128'(frames_dropped), 128'(4'hF));
        chk("t8_other_counts", 128'({frames_baser, frames_baset}), 128'({4'd3, 4'd4}));

        // Reset mid-frame: no drop pulse, counters cleared.
        baser_up = 1'b1;
        step(1, 1, 0, 0, 4'b1100, 4'b0000, 2'd1, "t9_start");
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("t9_reset_strobes", 128'({r_if.start, r_if.data_valid, r_if.commit, r_if.drop,
                                      t_if.start, t_if.data_valid, t_if.commit, t_if.drop, active_port}), 128'(0));
        chk("t9_reset_counters", 128'({frames_baser, frames_baset, frames_dropped}), 128'(0));
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/eth_tx_link_steering.md
Name: eth_tx_link_steering

Overview:
- Transmit-side counterpart of the RX link-selection mux in the IP stack clock domain.
- Takes the single arbitrated layer-2 TX frame stream and steers each whole frame to exactly one MAC elastic buffer: the 10G BASE-R port if its link is up, otherwise the 1G BASE-T port.
- Handles link changes mid-frame by aborting cleanly, so no buffer ever holds a truncated frame marked committed.
- Keeps per-port frame counters and a drop counter.

Parameters:
DATA_WIDTH, 32, width of the tx data word; bytes_valid is $clog2(DATA_WIDTH/8)+1 bits wide.
CNT_WIDTH, 16, width of each saturating statistics counter.

Ports:
clk  in  1  IP stack clock; all logic is on its rising edge.
rst  in  1  synchronous, active-high reset.
baser_link_up  in  1  10G link status, already synchronized to clk.
baset_link_up  in  1  1G link status, already synchronized to clk.
in_start  in  1  first-cycle marker of an upstream frame.
in_data_valid  in  1  in_data holds a valid word.
in_bytes_valid  in  3  count of valid bytes in in_data (1-4), MSB-first.
in_data  in  DATA_WIDTH  frame payload word.
in_dst_mac  in  48  destination MAC; valid when in_start is high.
in_ethertype  in  16  ethertype; valid when in_start is high.
in_commit  in  1  frame complete, send it.
in_drop  in  1  upstream abort of the current frame.
baser_start, baser_data_valid, baser_commit, baser_drop  out  1 each  strobes to the 10G TX buffer.
baser_bytes_valid, baser_data, baser_dst_mac, baser_ethertype  out  3/DATA_WIDTH/48/16  field copies to the 10G TX buffer.
baset_*  out  same set and widths as baser_*  strobes and fields to the 1G TX buffer.
active_port  out  2  port of the frame in flight: 0 none, 1 baser, 2 baset, 3 discarding.
frames_baser  out  CNT_WIDTH  frames committed to the 10G port.
frames_baset  out  CNT_WIDTH  frames committed to the 1G port.
frames_dropped  out  CNT_WIDTH  frames aborted or discarded by this block (upstream in_drop is not counted).

Behaviour:
- All outputs are registered. Fixed latency: 1 cycle from input to steered output.
- Reset: all strobes 0; all field outputs 0; active_port=0; counters 0; state IDLE.
- Field outputs (data, bytes_valid, dst_mac, ethertype) copy the inputs to both ports every cycle. Only the strobes are gated.
- States: IDLE, FWD_R, FWD_T, DISCARD.
- IDLE, on in_start:
  - baser_link_up=1 -> assert baser_start, go FWD_R.
  - else baset_link_up=1 -> assert baset_start, go FWD_T.
  - else -> go DISCARD and increment frames_dropped.
  - Link status is sampled in the in_start cycle; 10G has priority.
- IDLE, on in_data_valid, in_commit or in_drop without a start: ignored, no output strobe.
- FWD_x, selected link still up:
  - in_data_valid is forwarded as x_data_valid.
  - in_commit -> x_commit, increment frames_x, go IDLE.
  - in_drop -> x_drop, go IDLE, no counter change.
- FWD_x, selected link low in any cycle (including the commit cycle):
  - Emit a single x_drop pulse and increment frames_dropped.
  - Go DISCARD. If the same cycle carries in_commit or in_drop, go IDLE instead.
  - The commit is never forwarded.
- The other link rising mid-frame has no effect; the frame finishes on its original port. The next frame re-evaluates port priority.
- FWD_x, in_start without a prior commit/drop (upstream protocol violation):
  - Emit x_drop for the old frame and increment frames_dropped.
  - Treat the cycle as a fresh in_start from IDLE. The new start strobe appears in the same output cycle as the drop; if the new frame goes to the same port, buffers see drop, then start.
- DISCARD:
  - All strobes are suppressed.
  - in_commit or in_drop -> IDLE.
  - in_start -> frame boundary; re-enter the IDLE decision for the new frame.
- At most one of x_commit/x_drop is high per port per cycle. Start strobes never fire on both ports in one cycle.
- Counters saturate at all-ones and do not wrap.
- active_port reflects the state after the registered update.
- rst mid-frame: return to IDLE and clear counters with no drop pulse emitted. The downstream buffers are reset by the same rst.

Test Plan:
- Both links up; 64-byte frame (start, 16 words, commit) -> baser_start at cycle+1, 16 baser_data_valid, baser_commit; no baset strobes; frames_baser=1.
- baser down, baset up; two back-to-back frames -> both on baset; frames_baset=2; active_port goes 2 then 0.
- baset frame; baser_link_up rises at word 5 -> frame completes on baset (baset_commit); next frame starts on baser.
- baser frame; baser_link_up drops at word 8 -> one baser_drop pulse; words 9..end and the commit suppressed; frames_dropped=1; active_port=3 until in_commit, then 0.
- Both links down; start + 10 words + commit -> no strobes on either port; frames_dropped=1; the following frame with baset up is routed to baset.
- Link falls in the same cycle as in_commit -> baser_drop, no baser_commit, state IDLE next cycle. Also: frames_dropped preloaded to 0xFFFF stays 0xFFFF after another drop.
